l2_arbiter: RTL and testbench
=============================

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_WIDTH, default 128, meaning refill block width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning request address width.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ic_valid_i  input  1  icache miss request; may be a single-cycle pulse.
REQ-006 SHALL have port ic_addr_i  input  ADDR_WIDTH  icache miss address, sampled with ic_valid_i.
REQ-007 SHALL have port ic_ready_o  output  1  icache refill-data-valid pulse.
REQ-008 SHALL have port ic_data_o  output  BLOCK_WIDTH  icache refill block.
REQ-009 SHALL have port dc_valid_i  input  1  dcache miss request; may be a single-cycle pulse.
REQ-010 SHALL have port dc_addr_i  input  ADDR_WIDTH  dcache miss address, sampled with dc_valid_i.
REQ-011 SHALL have port dc_ready_o  output  1  dcache refill-data-valid pulse.
REQ-012 SHALL have port dc_data_o  output  BLOCK_WIDTH  dcache refill block.
REQ-013 SHALL have port l2_valid_o  output  1  request to L2; held until l2_ready_i.
REQ-014 SHALL have port l2_addr_o  output  ADDR_WIDTH  address to L2; stable while l2_valid_o is high.
REQ-015 SHALL have port l2_ready_i  input  1  L2 data-valid; completes the current request in that cycle.
REQ-016 SHALL have port l2_data_i  input  BLOCK_WIDTH  L2 block, valid with l2_ready_i.
REQ-017 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 SHALL keep one pending flag and one address register per requester.
- On the requester's valid_i with its pending flag clear: set the flag and capture addr_i at the clock edge.
- valid_i while the flag is already set: ignored; the captured address is kept.
REQ-019 SHALL implement FSM IDLE -> GRANT -> RESP -> IDLE, with one L2 transaction outstanding at most.
REQ-020 In IDLE with at least one pending flag set, the block SHALL:
- select the granted requester;
- latch the grant;
- move to GRANT on the next edge.
REQ-021 Arbitration SHALL be round-robin on a 1-bit last_grant pointer:
- a lone pending requester wins;
- if both are pending, the requester not equal to last_grant wins;
- last_grant is updated on every IDLE->GRANT transition.
REQ-022 In GRANT, l2_valid_o SHALL be 1 and l2_addr_o SHALL equal the granted requester's captured address.
REQ-023 In GRANT with l2_ready_i=1, the block SHALL, on that edge:
- register l2_data_i into the response register;
- clear the granted pending flag;
- move to RESP.
REQ-024 l2_ready_i SHALL be ignored outside GRANT.
REQ-025 In RESP, exactly the granted requester's ready_o SHALL be 1 for one cycle, with data_o equal to the registered block; then IDLE.
REQ-026 ic_data_o and dc_data_o SHALL both present the response register continuously; only ready_o qualifies the data.
REQ-027 Minimum latency SHALL be 3 cycles: valid_i at cycle N, l2_valid_o at N+2, l2_ready_i at N+2, ready_o at N+3.
REQ-028 A requester whose pending flag is clear during RESP (including the one being served) SHALL have a new valid_i accepted in that cycle.
REQ-029 A request arriving in the same cycle that the other requester is granted SHALL wait; it is granted on the next IDLE.
REQ-030 No requester SHALL wait more than one other transaction once pending.
REQ-031 Outside GRANT, l2_valid_o SHALL be 0 and l2_addr_o SHALL be 0.

Reset
REQ-032 While rst_n=0, the block SHALL:
- go to IDLE;
- clear both pending flags, address registers and the response register to 0;
- set last_grant=dcache, so icache wins the first tie.
REQ-033 Outputs during and after reset SHALL be 0: ready_o, data_o, l2_valid_o, l2_addr_o, busy_o.
REQ-034 Reset asserted mid-GRANT or mid-RESP SHALL abandon the transaction; no ready_o pulse is emitted afterwards.

Verification
REQ-035 icache pulse ic_valid_i=1, ic_addr_i=0x0000_1040; L2 returns 0xA5..A5 in the first GRANT cycle -> l2_addr_o=0x0000_1040; ic_ready_o=1 exactly at N+3 with data 0xA5..A5; dc_ready_o stays 0.
REQ-036 Both pulse at the same cycle (ic 0x100, dc 0x200) after reset -> icache served first, then dcache; l2_addr_o sequence 0x100, 0x200.
REQ-037 Both requesters continuously re-request after each ready -> grants strictly alternate over 8 transactions.
REQ-038 L2 stalls 10 cycles in GRANT -> l2_valid_o high and l2_addr_o stable all 10 cycles; ready at stall end +1.
REQ-039 Second ic_valid_i with addr 0x300 while icache is pending at 0x100 -> 0x100 is issued; 0x300 is dropped.
REQ-040 rst_n=0 asserted during GRANT -> all outputs 0 immediately; no ready pulse after release.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 refill port between the icache and the dcache.
// Each requester has a pending flag and a captured address. A three-state FSM
// (IDLE -> GRANT -> RESP) keeps at most one L2 transaction outstanding. A tie
// goes to the requester that was not granted last time.
module l2_arbiter #(
    parameter int BLOCK_WIDTH = 128,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   ic_valid_i,
    input  logic [ADDR_WIDTH-1:0]  ic_addr_i,
    output logic                   ic_ready_o,
    output logic [BLOCK_WIDTH-1:0] ic_data_o,

    input  logic                   dc_valid_i,
    input  logic [ADDR_WIDTH-1:0]  dc_addr_i,
    output logic                   dc_ready_o,
    output logic [BLOCK_WIDTH-1:0] dc_data_o,

    output logic                   l2_valid_o,
    output logic [ADDR_WIDTH-1:0]  l2_addr_o,
    input  logic                   l2_ready_i,
    input  logic [BLOCK_WIDTH-1:0] l2_data_i,

    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Requester encoding used by grant_q and last_grant_q.
    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic                   ic_pend_q, ic_pend_d;
    logic                   dc_pend_q, dc_pend_d;
    logic [ADDR_WIDTH-1:0]  ic_addr_q, ic_addr_d;
    logic [ADDR_WIDTH-1:0]  dc_addr_q, dc_addr_d;
    logic [BLOCK_WIDTH-1:0] resp_q, resp_d;
    logic                   l2_done;

    // The L2 completes a transaction only while the FSM is in GRANT.
    assign l2_done = (state_q == GRANT) && l2_ready_i;

    // Pending flags: a new request is captured only while the flag is clear.
    // A repeat request while the flag is set is ignored and keeps the address.
    always_comb begin
        ic_pend_d = ic_pend_q;
        ic_addr_d = ic_addr_q;
        dc_pend_d = dc_pend_q;
        dc_addr_d = dc_addr_q;

        if (ic_pend_q) begin
            if (l2_done && (grant_q == GNT_IC)) begin
                ic_pend_d = 1'b0;
            end
        end else if (ic_valid_i) begin
            ic_pend_d = 1'b1;
            ic_addr_d = ic_addr_i;
        end

        if (dc_pend_q) begin
            if (l2_done && (grant_q == GNT_DC)) begin
                dc_pend_d = 1'b0;
            end
        end else if (dc_valid_i) begin
            dc_pend_d = 1'b1;
            dc_addr_d = dc_addr_i;
        end
    end

    // FSM next state: round-robin arbitration in IDLE, wait for L2 in GRANT,
    // one response cycle in RESP.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        resp_d       = resp_q;

        unique case (state_q)
            IDLE: begin
                if (ic_pend_q || dc_pend_q) begin
                    if (ic_pend_q && dc_pend_q) begin
                        grant_d = ~last_grant_q;
                    end else if (dc_pend_q) begin
                        grant_d = GNT_DC;
                    end else begin
                        grant_d = GNT_IC;
                    end
                    last_grant_d = grant_d;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (l2_ready_i) begin
                    resp_d  = l2_data_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    // last_grant starts at the dcache so that the icache wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IC;
            last_grant_q <= GNT_DC;
            ic_pend_q    <= 1'b0;
            dc_pend_q    <= 1'b0;
            ic_addr_q    <= '0;
            dc_addr_q    <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ic_pend_q    <= ic_pend_d;
            dc_pend_q    <= dc_pend_d;
            ic_addr_q    <= ic_addr_d;
            dc_addr_q    <= dc_addr_d;
            resp_q       <= resp_d;
        end
    end

    // The L2 request is driven only in GRANT; the address bus is zero otherwise.
    assign l2_valid_o = (state_q == GRANT);
    assign l2_addr_o  = (state_q == GRANT) ? ((grant_q == GNT_DC) ? dc_addr_q : ic_addr_q)
                                           : '0;

    // Both data buses always show the response register; ready_o qualifies it.
    assign ic_ready_o = (state_q == RESP) && (grant_q == GNT_IC);
    assign dc_ready_o = (state_q == RESP) && (grant_q == GNT_DC);
    assign ic_data_o  = resp_q;
    assign dc_data_o  = resp_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter. A background L2 responder answers
// requests after a programmable stall. A background monitor pops expected L2
// addresses and refill responses from scoreboard queues as the DUT emits them.
module tb_l2_arbiter;

    localparam int BW = 128;
    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          ic_valid_i;
    logic [AW-1:0] ic_addr_i;
    logic          ic_ready_o;
    logic [BW-1:0] ic_data_o;
    logic          dc_valid_i;
    logic [AW-1:0] dc_addr_i;
    logic          dc_ready_o;
    logic [BW-1:0] dc_data_o;
    logic          l2_valid_o;
    logic [AW-1:0] l2_addr_o;
    logic          l2_ready_i;
    logic [BW-1:0] l2_data_i;
    logic          busy_o;

    typedef struct packed {
        logic          who;   // 0 = icache, 1 = dcache
        logic [BW-1:0] data;
    } resp_t;

    resp_t         exp_resp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int total = 0;
    int bad   = 0;

    // L2 responder controls
    int            l2_stall   = 0;
    bit            use_fixed  = 0;
    logic [BW-1:0] fixed_data = '0;
    bit            spurious   = 0;

    l2_arbiter #(.BLOCK_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ic_valid_i (ic_valid_i),
        .ic_addr_i  (ic_addr_i),
        .ic_ready_o (ic_ready_o),
        .ic_data_o  (ic_data_o),
        .dc_valid_i (dc_valid_i),
        .dc_addr_i  (dc_addr_i),
        .dc_ready_o (dc_ready_o),
        .dc_data_o  (dc_data_o),
        .l2_valid_o (l2_valid_o),
        .l2_addr_o  (l2_addr_o),
        .l2_ready_i (l2_ready_i),
        .l2_data_i  (l2_data_i),
        .busy_o     (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Refill block the L2 model returns for a given address.
    function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_0F0F, a + 32'd1};
    endfunction

    // L2 responder: answers l2_valid_o after l2_stall waiting cycles.
    initial begin : l2_model
        int wcnt;
        wcnt       = 0;
        l2_ready_i = 1'b0;
        l2_data_i  = '0;
        forever begin
            @(negedge clk);
            if (l2_valid_o) begin
                if (wcnt >= l2_stall) begin
                    l2_ready_i = 1'b1;
                    l2_data_i  = use_fixed ? fixed_data : blk(l2_addr_o);
                end else begin
                    l2_ready_i = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt       = 0;
                l2_ready_i = spurious;
                l2_data_i  = spurious ? {4{32'hDEAD_BEEF}} : '0;
            end
        end
    end

    // Scoreboard monitor: L2 request addresses and refill responses.
    initial begin : monitor
        logic          prev_v;
        logic [AW-1:0] prev_a;
        logic [AW-1:0] ea;
        resp_t         er;
        logic [BW-1:0] got_d;
        prev_v = 1'b0;
        prev_a = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (l2_valid_o && !prev_v) begin
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL l2_req_unexpected: got addr=%h, required no request", l2_addr_o);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        if (l2_addr_o !== ea) begin
                            bad++;
                            $display("FAIL l2_addr: got %h, required %h", l2_addr_o, ea);
                        end
                    end
                end
                if (l2_valid_o && prev_v) begin
                    total++;
                    if (l2_addr_o !== prev_a) begin
                        bad++;
                        $display("FAIL l2_addr_stable: got %h, required %h", l2_addr_o, prev_a);
                    end
                end
                if (!l2_valid_o) begin
                    total++;
                    if (l2_addr_o !== '0) begin
                        bad++;
                        $display("FAIL l2_addr_idle: got %h, required 0", l2_addr_o);
                    end
                end
                if (ic_ready_o || dc_ready_o) begin
                    total++;
                    if (ic_ready_o && dc_ready_o) begin
                        bad++;
                        $display("FAIL both_ready: got ic=1 dc=1, required one");
                    end else if (exp_resp_q.size() == 0) begin
                        bad++;
                        $display("FAIL resp_unexpected: got ic=%0b dc=%0b, required none", ic_ready_o, dc_ready_o);
                    end else begin
                        er    = exp_resp_q.pop_front();
                        got_d = dc_ready_o ? dc_data_o : ic_data_o;
                        if ((dc_ready_o !== er.who) || (got_d !== er.data)) begin
                            bad++;
                            $display("FAIL resp: got who=%0b data=%h, required who=%0b data=%h",
                                     dc_ready_o, got_d, er.who, er.data);
                        end
                    end
                end
            end
            prev_v = l2_valid_o;
            prev_a = l2_addr_o;
        end
    end

    // Waits (bounded) until the DUT is idle and the scoreboard has drained.
    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o && exp_resp_q.size() == 0 && exp_addr_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ic_valid_i = 1'b0;
        ic_addr_i  = '0;
        dc_valid_i = 1'b0;
        dc_addr_i  = '0;
        repeat (3) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            total++;
            if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready ph%0d: got ic=%b dc=%b, required 0", ph, ic_ready_o, dc_ready_o);
            end
            total++;
            if (ic_data_o !== '0 || dc_data_o !== '0) begin
                bad++;
                $display("FAIL reset_data ph%0d: got ic=%h dc=%h, required 0", ph, ic_data_o, dc_data_o);
            end
            total++;
            if (l2_valid_o !== 1'b0 || l2_addr_o !== '0) begin
                bad++;
                $display("FAIL reset_l2 ph%0d: got v=%b a=%h, required 0", ph, l2_valid_o, l2_addr_o);
            end
            total++;
            if (busy_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy ph%0d: got %b, required 0", ph, busy_o);
            end
            if (ph == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_single_latency();
        bit to;
        resp_t r;
        use_fixed  = 1'b1;
        fixed_data = {16{8'hA5}};
        exp_addr_q.push_back(32'h0000_1040);
        r.who  = 1'b0;
        r.data = {16{8'hA5}};
        exp_resp_q.push_back(r);
        @(posedge clk);
        #1;
        ic_valid_i = 1'b1;
        ic_addr_i  = 32'h0000_1040;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) ic_valid_i = 1'b0;
            @(negedge clk);
            total++;
            if (l2_valid_o !== (k == 2) || ic_ready_o !== (k == 3) || dc_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL latency N+%0d: got l2v=%b icr=%b dcr=%b, required l2v=%b icr=%b dcr=0",
                         k, l2_valid_o, ic_ready_o, dc_ready_o, (k == 2), (k == 3));
            end
        end
        wait_idle(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL single_timeout: got busy=%b, required idle", busy_o);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        bit to;
        resp_t r;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h200);
        r.who = 1'b0; r.data = blk(32'h100); exp_resp_q.push_back(r);
        r.who = 1'b1; r.data = blk(32'h200); exp_resp_q.push_back(r);
        ic_valid_i = 1'b1; ic_addr_i = 32'h100;
        dc_valid_i = 1'b1; dc_addr_i = 32'h200;
        @(posedge clk);
        #1;
        ic_valid_i = 1'b0;
        dc_valid_i = 1'b0;
        wait_idle(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL tie_timeout: got resp left=%0d, required 0", exp_resp_q.size());
        end
    endtask

    task automatic test_alternate();
        resp_t r;
        int cnt;
        bit to;
        for (int i = 0; i < 8; i++) begin
            r.who  = i[0];
            r.data = blk(i[0] ? 32'h2000 : 32'h1000);
            exp_resp_q.push_back(r);
            exp_addr_q.push_back(i[0] ? 32'h2000 : 32'h1000);
        end
        cnt = 0;
        @(posedge clk);
        #1;
        ic_valid_i = 1'b1; ic_addr_i = 32'h1000;
        dc_valid_i = 1'b1; dc_addr_i = 32'h2000;
        for (int c = 0; c < 200 && cnt < 8; c++) begin
            @(negedge clk);
            if (ic_ready_o || dc_ready_o) begin
                cnt++;
                total++;
                if (dc_ready_o !== (cnt % 2 == 0)) begin
                    bad++;
                    $display("FAIL alternate #%0d: got dc_ready=%b, required %b", cnt, dc_ready_o, (cnt % 2 == 0));
                end
                if (cnt == 7) ic_valid_i = 1'b0;
                if (cnt == 8) dc_valid_i = 1'b0;
            end
        end
        ic_valid_i = 1'b0;
        dc_valid_i = 1'b0;
        total++;
        if (cnt != 8) begin
            bad++;
            $display("FAIL alternate_count: got %0d, required 8", cnt);
        end
        wait_idle(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL alternate_timeout: got resp left=%0d, required 0", exp_resp_q.size());
        end
    endtask

    task automatic test_stall();
        resp_t r;
        int vcnt, cyc, last_v, rdy;
        bit to;
        l2_stall = 10;
        exp_addr_q.push_back(32'h4440);
        r.who = 1'b0; r.data = blk(32'h4440); exp_resp_q.push_back(r);
        vcnt = 0; last_v = -1; rdy = -1;
        @(posedge clk);
        #1;
        ic_valid_i = 1'b1; ic_addr_i = 32'h4440;
        @(posedge clk);
        #1 ic_valid_i = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (l2_valid_o) begin
                vcnt++;
                last_v = cyc;
            end
            if (ic_ready_o) begin
                rdy = cyc;
                break;
            end
        end
        total++;
        if (vcnt != 11) begin
            bad++;
            $display("FAIL stall_valid_cycles: got %0d, required 11", vcnt);
        end
        total++;
        if (rdy != last_v + 1 || rdy < 0) begin
            bad++;
            $display("FAIL stall_ready_cycle: got %0d, required %0d", rdy, last_v + 1);
        end
        l2_stall = 0;
        wait_idle(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL stall_timeout: got resp left=%0d, required 0", exp_resp_q.size());
        end
    endtask

    task automatic test_drop_and_hold();
        resp_t r;
        bit to;
        exp_addr_q.push_back(32'h100);
        r.who = 1'b0; r.data = blk(32'h100); exp_resp_q.push_back(r);
        @(posedge clk);
        #1;
        ic_valid_i = 1'b1; ic_addr_i = 32'h100;
        @(posedge clk);
        #1 ic_addr_i = 32'h300;
        @(posedge clk);
        #1 ic_valid_i = 1'b0;
        wait_idle(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL drop_timeout: got resp left=%0d, required 0", exp_resp_q.size());
        end
        // L2 ready outside GRANT must be ignored and the data buses must hold.
        spurious = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL spurious_ready: got icr=%b dcr=%b busy=%b, required 0", ic_ready_o, dc_ready_o, busy_o);
            end
        end
        spurious = 1'b0;
        @(negedge clk);
        total++;
        if (ic_data_o !== blk(32'h100) || dc_data_o !== blk(32'h100)) begin
            bad++;
            $display("FAIL data_hold: got ic=%h dc=%h, required %h", ic_data_o, dc_data_o, blk(32'h100));
        end
    endtask

    task automatic test_reset_mid_grant();
        bit seen;
        l2_stall = 5;
        exp_addr_q.push_back(32'h500);
        @(posedge clk);
        #1;
        ic_valid_i = 1'b1; ic_addr_i = 32'h500;
        @(posedge clk);
        #1 ic_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l2_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midrst_grant: got l2_valid=0, required 1");
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (l2_valid_o !== 1'b0 || l2_addr_o !== '0 || busy_o !== 1'b0 ||
            ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0 || ic_data_o !== '0 || dc_data_o !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got l2v=%b l2a=%h busy=%b icr=%b dcr=%b icd=%h, required all 0",
                     l2_valid_o, l2_addr_o, busy_o, ic_ready_o, dc_ready_o, ic_data_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        l2_stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after: got icr=%b dcr=%b busy=%b, required 0", ic_ready_o, dc_ready_o, busy_o);
            end
        end
        total++;
        if (exp_addr_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_req: got pending expectations=%0d, required 0", exp_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_tie_after_reset();
        test_alternate();
        test_stall();
        test_drop_and_hold();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
